// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_divider_pkg;

   localparam int DEFAULT_WIDTH = 16;

   // Replicated across the quotient width to form the all-ones divide-by-zero result
   localparam logic DBZ_QUOTIENT_BIT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage

// File: rtl/seq_divider_borrow.sv
// rtl/seq_divider_borrow.sv - a - b as a + ~b + 1 with 4-bit generate/propagate lookahead groups
module sub_borrow_unit #(
   parameter int W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   localparam int NG = (W + 3) / 4;

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W-1:0] c;
   logic [NG:0]  gc;

   assign g     = a & ~b;
   assign p     = a ^ ~b;
   assign gc[0] = 1'b1;

   for (genvar gi = 0; gi < NG; gi++) begin : g_group
      localparam int LO = gi * 4;
      localparam int N  = ((W - LO) < 4) ? (W - LO) : 4;

      // pg/pp[k] are the group-local generate/propagate of bits LO..LO+k-1
      logic [N:0] pg;
      logic [N:0] pp;

      assign pg[0] = 1'b0;
      assign pp[0] = 1'b1;

      for (genvar k = 0; k < N; k++) begin : g_bit
         assign c[LO+k]  = pg[k] | (pp[k] & gc[gi]);
         assign pg[k+1]  = g[LO+k] | (p[LO+k] & pg[k]);
         assign pp[k+1]  = pp[k] & p[LO+k];
      end

      assign gc[gi+1] = pg[N] | (pp[N] & gc[gi]);
   end

   assign diff   = p ^ c;
   assign borrow = ~gc[NG];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       state;
   div_state_t       next_state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] dvsr_reg;
   logic [CNT_W-1:0] cnt;
   logic             dbz_reg;
   logic [WIDTH:0]   rs;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             unused_diff_msb;

   assign rs = {rem_reg, q_reg[WIDTH-1]};

   sub_borrow_unit #(.W(WIDTH + 1)) u_sub (
      .a      (rs),
      .b      ({1'b0, dvsr_reg}),
      .diff   (diff),
      .borrow (borrow)
   );

   // Without a borrow the difference is below the divisor, so its top bit is always zero
   assign unused_diff_msb = diff[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = (divisor == '0) ? DONE : CALC;
         end
         CALC: begin
            if (cnt == CNT_W'(WIDTH - 1)) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg    <= '0;
         rem_reg  <= '0;
         dvsr_reg <= '0;
         cnt      <= '0;
         dbz_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvsr_reg <= divisor;
                  cnt      <= '0;
                  if (divisor == '0) begin
                     q_reg   <= {WIDTH{DBZ_QUOTIENT_BIT}};
                     rem_reg <= dividend;
                     dbz_reg <= 1'b1;
                  end else begin
                     q_reg   <= dividend;
                     rem_reg <= '0;
                     dbz_reg <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem_reg <= borrow ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
               q_reg   <= {q_reg[WIDTH-2:0], ~borrow};
               cnt     <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign quotient    = q_reg;
   assign remainder   = rem_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and streamed checks of seq_divider results, latency and handshakes
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Called #1 after a rising edge with the divider idle; lat counts edges after the accept edge
   task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r, output logic z,
                          output int lat, output logic ready_seen);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      lat        = 0;
      ready_seen = in_ready;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (in_ready) ready_seen = 1'b1;
      end
      q = quotient;
      r = remainder;
      z = div_by_zero;
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dividend  = '0;
      divisor   = '0;
      #12;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if (quotient !== 16'h0) begin tests_failed++; $display("FAIL reset_quotient: got %h expected 0000", quotient); end
      tests_run++;
      if (remainder !== 16'h0) begin tests_failed++; $display("FAIL reset_remainder: got %h expected 0000", remainder); end
      tests_run++;
      if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [15:0] q, r;
      logic z, rs;
      int lat;
      run_div(16'd100, 16'd7, q, r, z, lat, rs);
      tests_run++;
      if (q !== 16'd14) begin tests_failed++; $display("FAIL basic_quotient: got %0d expected 14", q); end
      tests_run++;
      if (r !== 16'd2) begin tests_failed++; $display("FAIL basic_remainder: got %0d expected 2", r); end
      tests_run++;
      if (z !== 1'b0) begin tests_failed++; $display("FAIL basic_dbz: got %b expected 0", z); end
      tests_run++;
      if (lat !== 16) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 16", lat); end
      tests_run++;
      if (rs !== 1'b0) begin tests_failed++; $display("FAIL basic_in_ready_busy: got %b expected 0", rs); end
   endtask

   task automatic test_extremes();
      logic [15:0] q, r;
      logic z, rs;
      int lat;
      run_div(16'hFFFF, 16'h0001, q, r, z, lat, rs);
      tests_run++;
      if (q !== 16'hFFFF || r !== 16'h0000) begin
         tests_failed++; $display("FAIL max_by_one: got q=%h r=%h expected q=ffff r=0000", q, r);
      end
      run_div(16'h0003, 16'hFFFF, q, r, z, lat, rs);
      tests_run++;
      if (q !== 16'h0000 || r !== 16'h0003) begin
         tests_failed++; $display("FAIL small_by_max: got q=%h r=%h expected q=0000 r=0003", q, r);
      end
   endtask

   task automatic test_div_zero();
      logic [15:0] q, r;
      logic z, rs;
      int lat;
      run_div(16'd5, 16'd0, q, r, z, lat, rs);
      tests_run++;
      if (z !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag: got %b expected 1", z); end
      tests_run++;
      if (q !== 16'hFFFF) begin tests_failed++; $display("FAIL dbz_quotient: got %h expected ffff", q); end
      tests_run++;
      if (r !== 16'd5) begin tests_failed++; $display("FAIL dbz_remainder: got %0d expected 5", r); end
      tests_run++;
      if (lat !== 0) begin tests_failed++; $display("FAIL dbz_immediate_valid: got %0d extra edges expected 0", lat); end
   endtask

   task automatic test_backpressure();
      logic [15:0] q, r;
      logic z, rs, hold_bad;
      int lat;
      out_ready = 1'b0;
      run_div(16'd1000, 16'd33, q, r, z, lat, rs);
      tests_run++;
      if (q !== 16'd30 || r !== 16'd10 || lat !== 16) begin
         tests_failed++; $display("FAIL bp_result: got q=%0d r=%0d lat=%0d expected q=30 r=10 lat=16", q, r, lat);
      end
      hold_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         dividend = 16'd7;
         divisor  = 16'd7;
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || quotient !== 16'd30 || remainder !== 16'd10 || in_ready !== 1'b0)
            hold_bad = 1'b1;
      end
      tests_run++;
      if (hold_bad !== 1'b0) begin tests_failed++; $display("FAIL bp_hold_stable: got %b expected 0", hold_bad); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
      end
      run_div(16'd8, 16'd3, q, r, z, lat, rs);
      tests_run++;
      if (q !== 16'd2 || r !== 16'd2) begin
         tests_failed++; $display("FAIL bp_resume: got q=%0d r=%0d expected q=2 r=2", q, r);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [15:0] q, r;
      logic z, rs;
      int lat;
      dividend = 16'hABCD;
      divisor  = 16'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got v=%b q=%h r=%h z=%b expected all zero", out_valid, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_div(16'hABCD, 16'd3, q, r, z, lat, rs);
      tests_run++;
      if (q !== 16'h3944 || r !== 16'd1 || lat !== 16) begin
         tests_failed++; $display("FAIL midreset_rerun: got q=%h r=%0d lat=%0d expected q=3944 r=1 lat=16", q, r, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b, q, r, eq, er;
      logic z, ez, rs;
      int lat, elat;
      for (int i = 0; i < 200; i++) begin
         case (i % 5)
            0: begin a = 16'($urandom_range(0, 65535)); b = 16'd0; end
            1: begin a = 16'($urandom_range(0, 65534)); b = 16'($urandom_range(int'(a) + 1, 65535)); end
            2: begin a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(1, 15)); end
            default: begin a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(1, 65535)); end
         endcase
         if (b == 16'd0) begin
            eq = 16'hFFFF; er = a; ez = 1'b1; elat = 0;
         end else begin
            eq = a / b; er = a % b; ez = 1'b0; elat = 16;
         end
         run_div(a, b, q, r, z, lat, rs);
         tests_run++;
         if (q !== eq || r !== er || z !== ez) begin
            tests_failed++;
            $display("FAIL stream_result %0d (%h/%h): got q=%h r=%h z=%b expected q=%h r=%h z=%b", i, a, b, q, r, z, eq, er, ez);
         end
         tests_run++;
         if (lat !== elat) begin tests_failed++; $display("FAIL stream_latency %0d: got %0d expected %0d", i, lat, elat); end
         if (b != 16'd0) begin
            tests_run++;
            if (int'(q) * int'(b) + int'(r) !== int'(a)) begin
               tests_failed++; $display("FAIL stream_identity %0d: got %0d expected %0d", i, int'(q) * int'(b) + int'(r), a);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
